uart_prog_loader: RTL and testbench

Parametrised UART program loader between the board's serial input pin and the CPU instruction memory. It receives a framed image over `uart_rx_pin`, assembles bytes into `DATA_W`-bit words and writes them to consecutive memory addresses. While loading it holds the CPU via `wait_transport`. It reports completion or a coded error, replacing hand-forced `wait_transport` and pin stimulus with a synthesizable boot path.

---
 rtl/uart_prog_loader_if.sv | 11 +
 rtl/uart_prog_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: instruction-memory write port driven by the UART loader
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 receiver plus frame loader writing little-endian words to instruction memory
module uart_prog_loader #(
  parameter int CLK_DIV     = 434,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                uart_rx_pin,
  uart_prog_loader_if.master  mem,
  output logic                wait_transport,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_count
);
  localparam int BPW = DATA_W / 8;
  localparam int LW  = BPW > 1 ? $clog2(BPW) : 1;
  localparam int CW  = $clog2(CLK_DIV);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

  rx_state_t rx_st, rx_st_n;
  logic [2:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] rx_byte, sh_n;
  logic rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;
  logic line, fall;

  ld_state_t ld_st, ld_st_n;
  logic [15:0] len, len_n, len_hi;
  logic [7:0] chk, chk_n;
  logic [LW-1:0] lane, lane_n;
  logic [DATA_W-1:0] wbuf, wbuf_n, wnew, wdata_q, wdata_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [ADDR_W:0] wc_n;
  logic [1:0] err_n;
  logic wt_n, done_n, we_q, we_n;
  logic in_frame, len_ovf, lane_last, last_word;

  // sync[1] is the synchronised line, sync[2] its value one clock earlier
  assign line = sync[1];
  assign fall = sync[2] & ~sync[1];

  always_comb begin
    rx_st_n = rx_st;
    cnt_n = cnt - CW'(1);
    bit_idx_n = bit_idx;
    sh_n = rx_byte;
    rx_valid_n = 1'b0;
    rx_ferr_n = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        cnt_n = CW'(CLK_DIV / 2 - 1);
        rx_st_n = fall ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt == '0) begin
        cnt_n = CW'(CLK_DIV - 1);
        bit_idx_n = '0;
        rx_st_n = line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == '0) begin
        cnt_n = CW'(CLK_DIV - 1);
        sh_n = {line, rx_byte[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        rx_st_n = bit_idx == 3'd7 ? RX_STOP : RX_DATA;
      end
      default: if (cnt == '0) begin
        rx_valid_n = line;
        rx_ferr_n = ~line;
        rx_st_n = RX_IDLE;
      end
    endcase
  end

  assign in_frame  = ld_st inside {L_LEN0, L_LEN1, L_DATA, L_CSUM};
  assign len_hi    = {rx_byte, len[7:0]};
  assign len_ovf   = 32'(len_hi) > (32'd1 << ADDR_W);
  assign lane_last = lane == LW'(BPW - 1);
  assign last_word = 32'(word_count) + 32'd1 == 32'(len);

  always_comb begin
    ld_st_n = ld_st;
    len_n = len;
    chk_n = chk;
    lane_n = lane;
    wbuf_n = wbuf;
    wt_n = wait_transport;
    done_n = done;
    err_n = err_code;
    wc_n = word_count;
    we_n = 1'b0;
    addr_n = addr_q;
    wdata_n = wdata_q;
    tcnt_n = (in_frame && !rx_valid) ? tcnt + TW'(1) : '0;
    wnew = wbuf;
    wnew[8*int'(lane) +: 8] = rx_byte;
    if (!in_frame) begin
      if (rx_valid && rx_byte == 8'hA5) begin
        ld_st_n = L_LEN0;
        wt_n = 1'b1;
        done_n = 1'b0;
        err_n = 2'b00;
        wc_n = '0;
        addr_n = '0;
        chk_n = '0;
        lane_n = '0;
      end
    end else if (rx_ferr) begin
      ld_st_n = L_ERR;
      wt_n = 1'b0;
      err_n = 2'b01;
    end else if (rx_valid) begin
      chk_n = chk ^ rx_byte;
      case (ld_st)
        L_LEN0: begin
          len_n[7:0] = rx_byte;
          ld_st_n = L_LEN1;
        end
        L_LEN1: begin
          len_n = len_hi;
          ld_st_n = len_ovf ? L_ERR : (len_hi == 16'd0 ? L_CSUM : L_DATA);
          err_n = len_ovf ? 2'b11 : 2'b00;
          wt_n = !len_ovf;
        end
        L_DATA: begin
          wbuf_n = wnew;
          lane_n = lane_last ? '0 : lane + LW'(1);
          if (lane_last) begin
            we_n = 1'b1;
            addr_n = word_count[ADDR_W-1:0];
            wdata_n = wnew;
            wc_n = word_count + (ADDR_W+1)'(1);
            ld_st_n = last_word ? L_CSUM : L_DATA;
          end
        end
        default: begin
          ld_st_n = chk == rx_byte ? L_DONE : L_ERR;
          done_n = chk == rx_byte;
          err_n = chk == rx_byte ? 2'b00 : 2'b10;
          wt_n = 1'b0;
        end
      endcase
    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
      ld_st_n = L_ERR;
      wt_n = 1'b0;
      err_n = 2'b11;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync <= 3'b111;
      rx_st <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      ld_st <= L_IDLE;
      len <= '0;
      chk <= '0;
      lane <= '0;
      wbuf <= '0;
      tcnt <= '0;
      wait_transport <= 1'b0;
      done <= 1'b0;
      err_code <= 2'b00;
      word_count <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      sync <= {sync[1:0], uart_rx_pin};
      rx_st <= rx_st_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      rx_byte <= sh_n;
      rx_valid <= rx_valid_n;
      rx_ferr <= rx_ferr_n;
      ld_st <= ld_st_n;
      len <= len_n;
      chk <= chk_n;
      lane <= lane_n;
      wbuf <= wbuf_n;
      tcnt <= tcnt_n;
      wait_transport <= wt_n;
      done <= done_n;
      err_code <= err_n;
      word_count <= wc_n;
      we_q <= we_n;
      addr_q <= addr_n;
      wdata_q <= wdata_n;
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: serial frames (directed and random) checked against a frame-level model
module tb_uart_prog_loader;
  localparam int CLK_DIV     = 16;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 500;
  localparam int BPW         = DATA_W / 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic uart_rx_pin = 1'b1;
  logic wait_transport, done;
  logic [1:0] err_code;
  logic [ADDR_W:0] word_count;

  uart_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

  uart_prog_loader #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .uart_rx_pin(uart_rx_pin),
    .mem(mbus),
    .wait_transport(wait_transport),
    .done(done),
    .err_code(err_code),
    .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int req_seq = 0;
  int ack_seq = 0;
  wr_t exp_q[$];
  logic exp_done = 1'b0;
  logic exp_wt = 1'b0;
  logic [1:0] exp_err = 2'b00;
  logic [ADDR_W:0] exp_wc = '0;
  string chk_name = "";

  task automatic cmp(input string what, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", what, act, req);
    end
  endtask

  // single compare process: every write strobe, the stall invariant, and requested status snapshots
  initial begin : compare_p
    wr_t e;
    forever begin
      @(negedge CLK);
      if (mbus.mem_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %h, want no write", mbus.mem_addr, mbus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          cmp("write_addr", 64'(mbus.mem_addr), 64'(e.a));
          cmp("write_data", 64'(mbus.mem_wdata), 64'(e.d));
          cmp("write_count", 64'(word_count), 64'(e.a) + 64'd1);
        end
      end
      if (wait_transport) cmp("stall_status", 64'({done, err_code}), 64'd0);
      if (req_seq != ack_seq) begin
        cmp({chk_name, "_done"}, 64'(done), 64'(exp_done));
        cmp({chk_name, "_err"}, 64'(err_code), 64'(exp_err));
        cmp({chk_name, "_wait"}, 64'(wait_transport), 64'(exp_wt));
        cmp({chk_name, "_count"}, 64'(word_count), 64'(exp_wc));
        cmp({chk_name, "_pending"}, 64'(exp_q.size()), 64'd0);
        ack_seq = req_seq;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name);
    chk_name = name;
    req_seq++;
    for (int i = 0; i < 10 && ack_seq != req_seq; i++) @(posedge CLK);
    if (ack_seq != req_seq) begin
      $display("FAIL %s: compare process did not respond", name);
      $fatal(1);
    end
    #1;
  endtask

  task automatic set_exp(input logic d, input logic [1:0] e, input logic wt, input int wc);
    exp_done = d;
    exp_err = e;
    exp_wt = wt;
    exp_wc = (ADDR_W+1)'(wc);
  endtask

  task automatic send_bit(input logic v);
    uart_rx_pin = v;
    idle(CLK_DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input bq_t fr, input int ferr_at, input int gmax);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], i != ferr_at);
      if (i == ferr_at) begin
        uart_rx_pin = 1'b1;
        break;
      end
      idle($urandom_range(0, gmax));
    end
    idle(2 * CLK_DIV);
  endtask

  function automatic bq_t rand_frame(input int len, input bit bad_chk);
    bq_t f;
    logic [7:0] x, b;
    f.push_back(8'hA5);
    f.push_back(8'(len));
    f.push_back(8'(len >> 8));
    x = f[1] ^ f[2];
    for (int i = 0; i < len * BPW; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(bad_chk ? ~x : x);
    return f;
  endfunction

  // frame-level reference: which words land where and how the frame ends, from the bytes actually sent
  task automatic model_frame(input bq_t fr, input int ferr_at);
    int n, len, words, need;
    logic [7:0] x;
    wr_t w;
    n = ferr_at >= 0 ? ferr_at : fr.size();
    exp_done = 1'b0;
    exp_wt = 1'b0;
    exp_wc = '0;
    if (n < 3) begin
      exp_err = ferr_at >= 0 ? 2'b01 : 2'b11;
      return;
    end
    len = int'(fr[1]) + 256 * int'(fr[2]);
    if (len > (1 << ADDR_W)) begin
      exp_err = 2'b11;
      return;
    end
    words = (n - 3) / BPW;
    if (words > len) words = len;
    for (int k = 0; k < words; k++) begin
      w.a = ADDR_W'(k);
      for (int j = 0; j < BPW; j++) w.d[8*j +: 8] = fr[3 + k * BPW + j];
      exp_q.push_back(w);
    end
    exp_wc = (ADDR_W+1)'(words);
    need = 4 + len * BPW;
    if (ferr_at >= 0) exp_err = 2'b01;
    else if (n < need) exp_err = 2'b11;
    else begin
      x = 8'h00;
      for (int k = 1; k < need - 1; k++) x ^= fr[k];
      exp_err = x == fr[need-1] ? 2'b00 : 2'b10;
    end
    exp_done = exp_err == 2'b00;
  endtask

  initial begin : main_p
    bq_t fr;
    wr_t w;
    int k;
    #2 RESET = 1'b0;
    @(posedge CLK);
    #1;
    idle(2);
    set_exp(1'b0, 2'b00, 1'b0, 0);
    check("reset");
    RESET = 1'b1;
    idle(4);

    uart_rx_pin = 1'b0;
    idle(3);
    uart_rx_pin = 1'b1;
    idle(3 * CLK_DIV);
    check("glitch");

    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b1);
    set_exp(1'b0, 2'b00, 1'b1, 0);
    check("header");
    w.a = 4'd0; w.d = 32'h12345678; exp_q.push_back(w);
    w.a = 4'd1; w.d = 32'hDEADBEEF; exp_q.push_back(w);
    for (int i = 3; i < 12; i++) send_byte(fr[i], 1'b1);
    idle(2 * CLK_DIV);
    set_exp(1'b1, 2'b00, 1'b0, 2);
    check("basic");

    fr[11] = 8'h29;
    w.a = 4'd0; w.d = 32'h12345678; exp_q.push_back(w);
    w.a = 4'd1; w.d = 32'hDEADBEEF; exp_q.push_back(w);
    send_frame(fr, -1, 4);
    set_exp(1'b0, 2'b10, 1'b0, 2);
    check("bad_chk");

    fr[11] = 8'h28;
    send_frame(fr, 6, 4);
    set_exp(1'b0, 2'b01, 1'b0, 0);
    check("framing");

    model_frame(fr, -1);
    send_frame(fr, -1, 4);
    check("fresh");

    fr = '{8'hA5, 8'h11, 8'h00};
    send_frame(fr, -1, 0);
    set_exp(1'b0, 2'b11, 1'b0, 0);
    check("len_overflow");

    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_frame(fr, -1);
    send_frame(fr, -1, 0);
    check("len_zero");

    fr = rand_frame(1 << ADDR_W, 1'b0);
    model_frame(fr, -1);
    send_frame(fr, -1, 0);
    check("max_len_stream");

    fr = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    send_frame(fr, -1, 0);
    idle(360);
    set_exp(1'b0, 2'b00, 1'b1, 0);
    check("pre_timeout");
    model_frame(fr, -1);
    idle(150);
    check("timeout");

    for (int t = 0; t < 8; t++) begin
      fr = rand_frame($urandom_range(1, 5), $urandom_range(0, 3) == 0);
      model_frame(fr, -1);
      send_frame(fr, -1, (t % 2) ? 0 : 20);
      check("random");
    end

    fr = rand_frame(3, 1'b0);
    k = $urandom_range(3, fr.size() - 1);
    model_frame(fr, k);
    send_frame(fr, k, 5);
    check("random_ferr");

    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    model_frame(fr, -1);
    send_frame(fr, -1, 3);
    set_exp(1'b0, 2'b00, 1'b1, 1);
    check("mid_data");
    #3 RESET = 1'b0;
    set_exp(1'b0, 2'b00, 1'b0, 0);
    check("reset_async");
    idle(3);
    RESET = 1'b1;
    fr = '{8'h77, 8'h88};
    send_frame(fr, -1, 0);
    check("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
